// File: rtl/battleship_pkg.sv
// Shared types and helpers for the battleship game controller: phase encoding,
// fleet sizing limits, winner codes and small arithmetic helpers.
package battleship_pkg;

  localparam int MAX_SHIPS = 5;
  localparam int LIFE_W    = 4;

  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_PLAYER = 2'd1;
  localparam logic [1:0] WIN_PC     = 2'd2;

  typedef enum logic [2:0] {
    PH_IDLE        = 3'd0,
    PH_PLACE       = 3'd1,
    PH_PC_PLACE    = 3'd2,
    PH_PLAYER_TURN = 3'd3,
    PH_PLAYER_WAIT = 3'd4,
    PH_PC_DELAY    = 3'd5,
    PH_PC_WAIT     = 3'd6,
    PH_GAME_OVER   = 3'd7
  } phase_e;

  function automatic logic [2:0] clamp_ships(input logic [2:0] req);
    if (req == 3'd0) return 3'd1;
    if (req > 3'(MAX_SHIPS)) return 3'(MAX_SHIPS);
    return req;
  endfunction

  // Ships have lengths N, N-1, ..., 1, so the fleet occupies N*(N+1)/2 cells.
  function automatic logic [LIFE_W-1:0] fleet_cells(input logic [2:0] n);
    int cells;
    cells = (int'(n) * (int'(n) + 1)) / 2;
    return LIFE_W'(cells);
  endfunction

  function automatic logic [LIFE_W-1:0] sat_dec(input logic [LIFE_W-1:0] v);
    return (v == '0) ? v : v - LIFE_W'(1);
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_if.sv
// Board-side signal bundle of the game controller. The controller drives the
// master side; the board / PC opponent logic sits on the slave side.
interface battleship_game_ctrl_if;
  import battleship_pkg::*;

  // Strobes (place_en, pc_place_start, shot_en, pc_shot_en) are single-cycle
  // registered pulses; shot_valid / pc_valid are only accepted while the
  // controller is waiting for that result, pc_place_done is a level.
  logic [2:0]        barcos;
  logic              attack;
  logic              poner;
  logic              place_ok;
  logic              place_en;
  logic [2:0]        ship_len;
  logic              pc_place_start;
  logic              pc_place_done;
  logic              shot_en;
  logic              auto_fire;
  logic              shot_valid;
  logic              shot_hit;
  logic              pc_shot_en;
  logic              pc_valid;
  logic              pc_hit;
  logic [2:0]        phase;
  logic [1:0]        winner;
  logic [LIFE_W-1:0] life_player;
  logic [LIFE_W-1:0] life_pc;

  modport master (
    input  barcos, attack, poner, place_ok, pc_place_done,
           shot_valid, shot_hit, pc_valid, pc_hit,
    output place_en, ship_len, pc_place_start, shot_en, auto_fire,
           pc_shot_en, phase, winner, life_player, life_pc
  );

  modport slave (
    output barcos, attack, poner, place_ok, pc_place_done,
           shot_valid, shot_hit, pc_valid, pc_hit,
    input  place_en, ship_len, pc_place_start, shot_en, auto_fire,
           pc_shot_en, phase, winner, life_player, life_pc
  );

endinterface

// File: rtl/battleship_turn_timer.sv
// Loadable down-counter shared by the player turn timeout and the PC think delay.
// expire is high for the single enabled cycle in which the count is 1.
module battleship_turn_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // A zero load is treated as one so the phase still ends after one cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? W'(1) : load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !load && (cnt_q == W'(1));

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: ship placement, PC fleet handshake, alternating
// player/PC shots with a turn timeout, life tracking and winner detection.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int TURN_CYCLES     = 750000000,
  parameter int PC_DELAY_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  battleship_game_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE        = PH_IDLE;
  localparam logic [2:0] S_PLACE       = PH_PLACE;
  localparam logic [2:0] S_PC_PLACE    = PH_PC_PLACE;
  localparam logic [2:0] S_PLAYER_TURN = PH_PLAYER_TURN;
  localparam logic [2:0] S_PLAYER_WAIT = PH_PLAYER_WAIT;
  localparam logic [2:0] S_PC_DELAY    = PH_PC_DELAY;
  localparam logic [2:0] S_PC_WAIT     = PH_PC_WAIT;
  localparam logic [2:0] S_GAME_OVER   = PH_GAME_OVER;

  localparam logic [31:0] TURN_LOAD  = 32'(TURN_CYCLES);
  localparam logic [31:0] DELAY_LOAD = 32'(PC_DELAY_CYCLES);

  logic [2:0]        state_q, state_d;
  logic [2:0]        ship_len_q, ship_len_d;
  logic [LIFE_W-1:0] life_player_q, life_player_d;
  logic [LIFE_W-1:0] life_pc_q, life_pc_d;
  logic [1:0]        winner_q, winner_d;
  logic              place_en_q, place_en_d;
  logic              pc_place_start_q, pc_place_start_d;
  logic              shot_en_q, shot_en_d;
  logic              auto_fire_q, auto_fire_d;
  logic              pc_shot_en_q, pc_shot_en_d;

  logic              timer_load;
  logic              timer_en;
  logic              timer_expire;
  logic [31:0]       timer_val;
  logic [2:0]        n_ships;

  battleship_turn_timer #(.W(32)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d          = state_q;
    ship_len_d       = ship_len_q;
    life_player_d    = life_player_q;
    life_pc_d        = life_pc_q;
    winner_d         = winner_q;
    place_en_d       = 1'b0;
    pc_place_start_d = 1'b0;
    shot_en_d        = 1'b0;
    auto_fire_d      = 1'b0;
    pc_shot_en_d     = 1'b0;
    timer_load       = 1'b0;
    timer_val        = TURN_LOAD;
    timer_en         = (state_q == S_PLAYER_TURN) || (state_q == S_PC_DELAY);
    n_ships          = clamp_ships(bus.barcos);

    case (state_q)
      S_IDLE: begin
        if (bus.attack) begin
          ship_len_d    = n_ships;
          life_player_d = fleet_cells(n_ships);
          life_pc_d     = fleet_cells(n_ships);
          state_d       = S_PLACE;
        end
      end

      S_PLACE: begin
        if (bus.poner && bus.place_ok) begin
          place_en_d = 1'b1;
          ship_len_d = ship_len_q - 3'd1;
          if (ship_len_q <= 3'd1) state_d = S_PC_PLACE;
        end
      end

      // The last place_en is still high on the first PC_PLACE cycle, so the
      // PC start strobe is issued one cycle later to keep strobes disjoint.
      S_PC_PLACE: begin
        pc_place_start_d = place_en_q;
        if (bus.pc_place_done && !place_en_q) begin
          state_d    = S_PLAYER_TURN;
          timer_load = 1'b1;
          timer_val  = TURN_LOAD;
        end
      end

      S_PLAYER_TURN: begin
        if (bus.attack) begin
          shot_en_d = 1'b1;
          state_d   = S_PLAYER_WAIT;
        end else if (timer_expire) begin
          shot_en_d   = 1'b1;
          auto_fire_d = 1'b1;
          state_d     = S_PLAYER_WAIT;
        end
      end

      S_PLAYER_WAIT: begin
        if (bus.shot_valid) begin
          if (bus.shot_hit) life_pc_d = sat_dec(life_pc_q);
          if (life_pc_d == '0) begin
            winner_d = WIN_PLAYER;
            state_d  = S_GAME_OVER;
          end else begin
            state_d    = S_PC_DELAY;
            timer_load = 1'b1;
            timer_val  = DELAY_LOAD;
          end
        end
      end

      S_PC_DELAY: begin
        if (timer_expire) begin
          pc_shot_en_d = 1'b1;
          state_d      = S_PC_WAIT;
        end
      end

      S_PC_WAIT: begin
        if (bus.pc_valid) begin
          if (bus.pc_hit) life_player_d = sat_dec(life_player_q);
          if (life_player_d == '0) begin
            winner_d = WIN_PC;
            state_d  = S_GAME_OVER;
          end else begin
            state_d    = S_PLAYER_TURN;
            timer_load = 1'b1;
            timer_val  = TURN_LOAD;
          end
        end
      end

      S_GAME_OVER: begin
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      ship_len_q       <= '0;
      life_player_q    <= '0;
      life_pc_q        <= '0;
      winner_q         <= WIN_NONE;
      place_en_q       <= 1'b0;
      pc_place_start_q <= 1'b0;
      shot_en_q        <= 1'b0;
      auto_fire_q      <= 1'b0;
      pc_shot_en_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      ship_len_q       <= ship_len_d;
      life_player_q    <= life_player_d;
      life_pc_q        <= life_pc_d;
      winner_q         <= winner_d;
      place_en_q       <= place_en_d;
      pc_place_start_q <= pc_place_start_d;
      shot_en_q        <= shot_en_d;
      auto_fire_q      <= auto_fire_d;
      pc_shot_en_q     <= pc_shot_en_d;
    end
  end

  assign bus.phase          = state_q;
  assign bus.ship_len       = ship_len_q;
  assign bus.life_player    = life_player_q;
  assign bus.life_pc        = life_pc_q;
  assign bus.winner         = winner_q;
  assign bus.place_en       = place_en_q;
  assign bus.pc_place_start = pc_place_start_q;
  assign bus.shot_en        = shot_en_q;
  assign bus.auto_fire      = auto_fire_q;
  assign bus.pc_shot_en     = pc_shot_en_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl: a clamp/life vector table plus
// hand-written sequences for placement, turns, timeouts and async reset.
module tb_battleship_game_ctrl;
  import battleship_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  battleship_game_ctrl_if bus();

  battleship_game_ctrl #(
    .TURN_CYCLES     (20),
    .PC_DELAY_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0] barcos;
    logic [2:0] exp_len;
    logic [3:0] exp_life;
  } clamp_vec_t;

  clamp_vec_t vecs[8];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.barcos        = 3'd0;
    bus.attack        = 1'b0;
    bus.poner         = 1'b0;
    bus.place_ok      = 1'b0;
    bus.pc_place_done = 1'b0;
    bus.shot_valid    = 1'b0;
    bus.shot_hit      = 1'b0;
    bus.pc_valid      = 1'b0;
    bus.pc_hit        = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},       32'(bus.phase),          32'(PH_IDLE));
    check({tag, "_ship_len"},    32'(bus.ship_len),       32'd0);
    check({tag, "_life_player"}, 32'(bus.life_player),    32'd0);
    check({tag, "_life_pc"},     32'(bus.life_pc),        32'd0);
    check({tag, "_winner"},      32'(bus.winner),         32'd0);
    check({tag, "_strobes"},     32'({bus.place_en, bus.pc_place_start, bus.shot_en,
                                      bus.auto_fire, bus.pc_shot_en}), 32'd0);
  endtask

  task automatic pulse_attack();
    bus.attack = 1'b1;
    tick();
    bus.attack = 1'b0;
  endtask

  task automatic pulse_poner();
    bus.poner = 1'b1;
    tick();
    bus.poner = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget);
    int n;
    n = 0;
    while (bus.phase !== p && n < budget) begin
      tick();
      n++;
    end
    check("wait_phase", 32'(bus.phase), 32'(p));
  endtask

  task automatic start_game(input logic [2:0] b, input int nships);
    apply_reset();
    bus.barcos = b;
    pulse_attack();
    bus.place_ok = 1'b1;
    for (int k = 0; k < nships; k++) begin
      pulse_poner();
      tick();
    end
    bus.place_ok = 1'b0;
    bus.pc_place_done = 1'b1;
    wait_phase(PH_PLAYER_TURN, 10);
    bus.pc_place_done = 1'b0;
  endtask

  initial begin
    int cnt;
    int early;

    vecs[0] = '{barcos: 3'd0, exp_len: 3'd1, exp_life: 4'd1};
    vecs[1] = '{barcos: 3'd1, exp_len: 3'd1, exp_life: 4'd1};
    vecs[2] = '{barcos: 3'd2, exp_len: 3'd2, exp_life: 4'd3};
    vecs[3] = '{barcos: 3'd3, exp_len: 3'd3, exp_life: 4'd6};
    vecs[4] = '{barcos: 3'd4, exp_len: 3'd4, exp_life: 4'd10};
    vecs[5] = '{barcos: 3'd5, exp_len: 3'd5, exp_life: 4'd15};
    vecs[6] = '{barcos: 3'd6, exp_len: 3'd5, exp_life: 4'd15};
    vecs[7] = '{barcos: 3'd7, exp_len: 3'd5, exp_life: 4'd15};

    // Reset state and idle hold without a qualifying input.
    clear_inputs();
    reset = 1'b1;
    tick();
    check_all_zero("in_reset");
    reset = 1'b0;
    bus.poner = 1'b1;
    bus.shot_valid = 1'b1;
    bus.pc_valid = 1'b1;
    repeat (3) tick();
    clear_inputs();
    check_all_zero("idle_hold");

    // Ship-count clamp and starting lives.
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      bus.barcos = vecs[i].barcos;
      pulse_attack();
      check("clamp_phase", 32'(bus.phase),       32'(PH_PLACE));
      check("clamp_len",   32'(bus.ship_len),    32'(vecs[i].exp_len));
      check("clamp_lifep", 32'(bus.life_player), 32'(vecs[i].exp_life));
      check("clamp_lifec", 32'(bus.life_pc),     32'(vecs[i].exp_life));
    end

    // Placement of a two-ship fleet.
    apply_reset();
    bus.barcos = 3'd2;
    pulse_attack();
    bus.place_ok = 1'b0;
    pulse_poner();
    check("bad_place_en",  32'(bus.place_en), 32'd0);
    check("bad_place_len", 32'(bus.ship_len), 32'd2);
    tick();
    bus.place_ok = 1'b1;
    bus.attack = 1'b1;
    pulse_poner();
    bus.attack = 1'b0;
    check("place1_en",    32'(bus.place_en), 32'd1);
    check("place1_len",   32'(bus.ship_len), 32'd1);
    check("place1_phase", 32'(bus.phase),    32'(PH_PLACE));
    tick();
    check("place1_width", 32'(bus.place_en), 32'd0);
    pulse_poner();
    check("place2_en",    32'(bus.place_en),       32'd1);
    check("place2_len",   32'(bus.ship_len),       32'd0);
    check("place2_phase", 32'(bus.phase),          32'(PH_PC_PLACE));
    check("place2_pcst",  32'(bus.pc_place_start), 32'd0);
    bus.place_ok = 1'b0;
    tick();
    check("pc_start_on",  32'(bus.pc_place_start), 32'd1);
    check("pc_start_pen", 32'(bus.place_en),       32'd0);
    tick();
    check("pc_start_off", 32'(bus.pc_place_start), 32'd0);
    check("pc_wait_done", 32'(bus.phase),          32'(PH_PC_PLACE));
    bus.pc_place_done = 1'b1;
    tick();
    bus.pc_place_done = 1'b0;
    check("enter_turn",   32'(bus.phase),          32'(PH_PLAYER_TURN));
    check("lives_2ship",  32'({bus.life_player, bus.life_pc}), 32'({4'd3, 4'd3}));

    // Single-ship game won by the player on the first shot.
    start_game(3'd1, 1);
    pulse_attack();
    check("shot_en",       32'(bus.shot_en),   32'd1);
    check("shot_manual",   32'(bus.auto_fire), 32'd0);
    check("shot_wait",     32'(bus.phase),     32'(PH_PLAYER_WAIT));
    tick();
    check("shot_width",    32'(bus.shot_en),   32'd0);
    bus.shot_valid = 1'b1;
    bus.shot_hit = 1'b1;
    tick();
    bus.shot_valid = 1'b0;
    bus.shot_hit = 1'b0;
    check("win_life_pc",   32'(bus.life_pc),   32'd0);
    check("win_winner",    32'(bus.winner),    32'(WIN_PLAYER));
    check("win_phase",     32'(bus.phase),     32'(PH_GAME_OVER));
    pulse_attack();
    bus.pc_valid = 1'b1;
    bus.pc_hit = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    bus.pc_hit = 1'b0;
    tick();
    check("over_phase",    32'(bus.phase),       32'(PH_GAME_OVER));
    check("over_winner",   32'(bus.winner),      32'(WIN_PLAYER));
    check("over_lives",    32'({bus.life_player, bus.life_pc}), 32'({4'd1, 4'd0}));
    check("over_strobes",  32'({bus.shot_en, bus.pc_shot_en}), 32'd0);

    // Turn timeout, PC delay length and PC hit.
    start_game(3'd2, 2);
    cnt = 0;
    while (!bus.shot_en && cnt < 40) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", 32'(cnt),           32'd20);
    check("timeout_auto",   32'(bus.auto_fire), 32'd1);
    check("timeout_phase",  32'(bus.phase),     32'(PH_PLAYER_WAIT));
    bus.shot_valid = 1'b1;
    bus.shot_hit = 1'b0;
    tick();
    bus.shot_valid = 1'b0;
    check("miss_phase",     32'(bus.phase),     32'(PH_PC_DELAY));
    check("miss_life_pc",   32'(bus.life_pc),   32'd3);
    cnt = 0;
    while (!bus.pc_shot_en && cnt < 20) begin
      tick();
      cnt++;
    end
    check("pc_delay_cycles", 32'(cnt),          32'd4);
    check("pc_wait_phase",   32'(bus.phase),    32'(PH_PC_WAIT));
    bus.pc_valid = 1'b1;
    bus.pc_hit = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    bus.pc_hit = 1'b0;
    check("pc_hit_life",     32'(bus.life_player), 32'd2);
    check("pc_hit_phase",    32'(bus.phase),       32'(PH_PLAYER_TURN));

    // Attack landing on the expiry cycle yields one manual shot.
    early = 0;
    repeat (19) begin
      tick();
      if (bus.shot_en) early++;
    end
    check("no_early_shot", 32'(early), 32'd0);
    pulse_attack();
    check("coinc_shot",   32'(bus.shot_en),   32'd1);
    check("coinc_auto",   32'(bus.auto_fire), 32'd0);
    tick();
    check("coinc_single", 32'(bus.shot_en),   32'd0);
    check("coinc_phase",  32'(bus.phase),     32'(PH_PLAYER_WAIT));
    bus.shot_valid = 1'b1;
    tick();
    bus.shot_valid = 1'b0;
    bus.shot_valid = 1'b1;
    bus.shot_hit = 1'b1;
    tick();
    bus.shot_valid = 1'b0;
    bus.shot_hit = 1'b0;
    check("spurious_life", 32'(bus.life_pc), 32'd3);
    check("spurious_phase", 32'(bus.phase),  32'(PH_PC_DELAY));
    wait_phase(PH_PC_WAIT, 10);

    // Asynchronous reset in PC_WAIT, then a clean restart.
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    reset = 1'b0;
    tick();
    bus.barcos = 3'd3;
    pulse_attack();
    check("restart_phase", 32'(bus.phase),    32'(PH_PLACE));
    check("restart_len",   32'(bus.ship_len), 32'd3);
    check("restart_lives", 32'({bus.life_player, bus.life_pc}), 32'({4'd6, 4'd6}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/battleship_game_ctrl.md
BATTLESHIP_GAME_CTRL -- requirements
Module: battleship_game_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 750000000: player-turn timeout in clocks (15 s at 50 MHz).
REQ-002 SHALL have parameter PC_DELAY_CYCLES, default 50000000: clocks the PC "thinks" before firing.
REQ-003 SHALL have the ports below. The design uses one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 barcos  in  3  requested ship count; latched on game start.
REQ-007 attack  in  1  single-cycle pulse; starts the game in IDLE and fires a shot in PLAYER_TURN.
REQ-008 poner  in  1  single-cycle pulse; requests placement of the current ship.
REQ-009 place_ok  in  1  from the board: the current cursor position is legal for a ship of length ship_len.
REQ-010 place_en  out  1  one-cycle strobe: write the player ship.
REQ-011 ship_len  out  3  length of the ship currently being placed.
REQ-012 pc_place_start  out  1  one-cycle strobe; pc_place_done  in  1  level input: PC fleet is placed.
REQ-013 shot_en  out  1  player shot strobe; auto_fire  out  1  qualifies shot_en as a timeout shot.
REQ-014 shot_valid  in  1  player shot result is valid; shot_hit  in  1  that shot hit.
REQ-015 pc_shot_en  out  1  PC shot strobe; pc_valid  in  1  PC shot result is valid; pc_hit  in  1  that shot hit.
REQ-016 phase  out  3  current state encoding; winner  out  2  game result: 0 none, 1 player, 2 PC.
REQ-017 life_player, life_pc  out  4 each  remaining ship cells per side.

Function
REQ-018 States SHALL be: IDLE, PLACE, PC_PLACE, PLAYER_TURN, PLAYER_WAIT, PC_DELAY, PC_WAIT, GAME_OVER.
REQ-019 In IDLE, an attack pulse SHALL latch N = clamp(barcos, 1, 5), load both lives with N*(N+1)/2, set ship_len=N, and go to PLACE.
REQ-020 In PLACE, poner with place_ok=1 SHALL assert place_en on the next cycle and decrement ship_len; poner with place_ok=0 SHALL be ignored.
REQ-021 Placing the ship with ship_len=1 SHALL cause a move to PC_PLACE with pc_place_start pulsed once; the FSM waits for pc_place_done=1, then enters PLAYER_TURN.
REQ-022 On entry to PLAYER_TURN the timer SHALL load TURN_CYCLES.
REQ-023 In PLAYER_TURN, an attack pulse SHALL cause a one-cycle shot_en with auto_fire=0, followed by PLAYER_WAIT.
REQ-024 In PLAYER_TURN, timer expiry SHALL cause shot_en with auto_fire=1, followed by PLAYER_WAIT.
REQ-025 If attack and timer expiry occur in the same cycle, exactly one shot SHALL be issued, with auto_fire=0.
REQ-026 In PLAYER_WAIT, shot_valid SHALL decrement life_pc if shot_hit is set. If life_pc then reaches 0, winner=1 and the FSM enters GAME_OVER; otherwise it enters PC_DELAY.
REQ-027 PC_DELAY SHALL count PC_DELAY_CYCLES, then pulse pc_shot_en and enter PC_WAIT.
REQ-028 In PC_WAIT, pc_valid SHALL decrement life_player if pc_hit is set. If life_player then reaches 0, winner=2 and the FSM enters GAME_OVER; otherwise it enters PLAYER_TURN.
REQ-029 Lives SHALL saturate at 0.
REQ-030 shot_valid and pc_valid arriving outside their wait state SHALL be ignored.
REQ-031 poner outside PLACE and attack in PLACE, PC_PLACE, or any wait state SHALL be ignored.
REQ-032 If poner and attack arrive together in PLACE, poner SHALL win.
REQ-033 GAME_OVER SHALL hold all outputs until reset; attack is ignored there.
REQ-034 All strobes SHALL be registered, exactly one cycle wide, and mutually exclusive.

Reset
REQ-035 Asserting reset at any time, including mid-turn, SHALL force IDLE immediately.
REQ-036 During reset, all strobes, auto_fire and ship_len SHALL be 0, life_player=life_pc=0, winner=0, phase=IDLE encoding, and the timer SHALL be cleared.
REQ-037 The first state change after reset deassertion SHALL occur only on a qualifying input.

Structure
REQ-038 Package battleship_pkg SHALL hold the state enum (phase encoding), MAX_SHIPS=5, LIFE_W=4 and the winner codes.
REQ-039 The timer SHALL be sub-module battleship_turn_timer, a load/enable down-counter with a one-cycle expire output, instantiated once and shared by PLAYER_TURN and PC_DELAY.

Verification (TURN_CYCLES=20, PC_DELAY_CYCLES=4)
REQ-040 barcos=2, attack, then poner with place_ok=1 twice -> ship_len goes 2,1,0; two place_en pulses; lives=3; pc_place_start pulsed; pc_place_done -> PLAYER_TURN.
REQ-041 barcos=0 -> N=1 and lives=1; barcos=7 -> N=5 and lives=15; poner with place_ok=0 -> no place_en and ship_len unchanged.
REQ-042 N=1 game: attack -> shot_en and auto_fire=0; shot_valid with shot_hit=1 -> life_pc=0, winner=1, GAME_OVER; later attack and pc_valid pulses change nothing.
REQ-043 No attack for 20 cycles in PLAYER_TURN -> shot_en with auto_fire=1; result miss -> pc_shot_en exactly 4 cycles after entering PC_DELAY; pc_hit=1 -> life_player decrements.
REQ-044 attack coincident with expiry -> single shot_en with auto_fire=0; spurious shot_valid during PC_DELAY -> life_pc unchanged.
REQ-045 reset asserted in PC_WAIT -> same-cycle IDLE with all outputs 0; a new game restarts cleanly.
